// File: rtl/mmh_hash_scheduler_if.sv
`default_nettype none
// ============================================================================
//  Module      : mmh_hash_scheduler_if
//  Description : Handshake and operand bundle between the MMH hash scheduler,
//                its key source, the shared modular multiplier and the
//                hash-output sink.
//  Revision    : 1.0  initial release
// ============================================================================
interface mmh_hash_scheduler_if #(
  parameter int DATA_WIDTH = 64
);
  logic                  start;
  logic                  busy;
  logic                  in_valid;
  logic                  in_ready;
  logic [DATA_WIDTH-1:0] in_x;
  logic [DATA_WIDTH-1:0] in_k;
  logic [DATA_WIDTH-1:0] mul_x;
  logic [DATA_WIDTH-1:0] mul_y;
  logic [DATA_WIDTH-1:0] mul_res;
  logic                  out_valid;
  logic                  out_ready;
  logic [DATA_WIDTH-1:0] out_hash;

  // Environment side: key source, multiplier result and hash sink
  modport master (
    output start, in_valid, in_x, in_k, mul_res, out_ready,
    input  busy, in_ready, mul_x, mul_y, out_valid, out_hash
  );

  // Scheduler side
  modport slave (
    input  start, in_valid, in_x, in_k, mul_res, out_ready,
    output busy, in_ready, mul_x, mul_y, out_valid, out_hash
  );
endinterface
`default_nettype wire

// File: rtl/mmh_hash_scheduler.sv
`default_nettype none
// ============================================================================
//  Module      : mmh_hash_scheduler
//  Description : Sequences one MMH dot-product block: accepts BLOCK_LEN
//                (x, k) pairs, issues them to a free-running pipelined
//                modular multiplier, tracks in-flight products with a token
//                shift register and accumulates returned products mod P.
//  Revision    : 1.0  initial release
// ============================================================================
module mmh_hash_scheduler #(
  parameter int                    DATA_WIDTH = 64,
  parameter int                    BLOCK_LEN  = 16,
  parameter int                    MUL_LAT    = 6,
  parameter logic [DATA_WIDTH-1:0] MODULUS    = 64'hFFFFFFFF00000001
) (
  input wire logic             clk,
  input wire logic             rst,
  mmh_hash_scheduler_if.slave  bus
);

  localparam int CNT_W = (BLOCK_LEN < 2) ? 1 : $clog2(BLOCK_LEN + 1);
  localparam int TOK_W = MUL_LAT + 1;

  localparam logic [CNT_W-1:0] C_LAST_CNT  = CNT_W'(BLOCK_LEN - 1);
  // Every token stage except the tail (stage MUL_LAT)
  localparam logic [TOK_W-1:0] C_REST_MASK = TOK_W'((64'd1 << MUL_LAT) - 64'd1);

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_ISSUE  = 2'd1;
  localparam logic [1:0] ST_DRAIN  = 2'd2;
  localparam logic [1:0] ST_OUTPUT = 2'd3;

  logic [1:0]            state_q, state_d;
  logic [CNT_W-1:0]      issue_cnt_q, issue_cnt_d;
  logic [TOK_W-1:0]      tok_q, tok_d;
  logic [DATA_WIDTH-1:0] acc_q, acc_d;
  logic [DATA_WIDTH-1:0] mul_x_q, mul_x_d;
  logic [DATA_WIDTH-1:0] mul_y_q, mul_y_d;

  logic                  w_busy;
  logic                  w_in_ready;
  logic                  w_out_valid;
  logic                  w_accept;
  logic                  w_start_go;
  logic                  w_last_accept;
  logic                  w_tail_tok;
  logic                  w_last_retire;
  logic [DATA_WIDTH:0]   w_sum;

  // Shared event decode used by both the FSM and the datapath
  always_comb begin
    w_accept      = bus.in_valid && (state_q == ST_ISSUE);
    w_start_go    = bus.start && (state_q == ST_IDLE);
    w_last_accept = w_accept && (issue_cnt_q == C_LAST_CNT);
    w_tail_tok    = tok_q[MUL_LAT];
    // In DRAIN no new tokens enter, so the tail is the last one when the
    // rest of the pipeline is already empty.
    w_last_retire = w_tail_tok && ((tok_q & C_REST_MASK) == '0);
  end

  // FSM state register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:   if (w_start_go)                       state_d = ST_ISSUE;
      ST_ISSUE:  if (w_last_accept)                    state_d = ST_DRAIN;
      ST_DRAIN:  if (w_last_retire)                    state_d = ST_OUTPUT;
      ST_OUTPUT: if (bus.out_ready)                    state_d = ST_IDLE;
      default:                                         state_d = ST_IDLE;
    endcase
  end

  // FSM outputs are pure functions of the current state
  always_comb begin
    w_busy      = (state_q != ST_IDLE);
    w_in_ready  = (state_q == ST_ISSUE);
    w_out_valid = (state_q == ST_OUTPUT);
  end

  // Datapath next values: operand capture, token shift, count, accumulate
  always_comb begin
    mul_x_d     = w_accept ? bus.in_x : mul_x_q;
    mul_y_d     = w_accept ? bus.in_k : mul_y_q;
    // Stage 0 receives a token on acceptance and a bubble otherwise
    tok_d       = (tok_q << 1) | TOK_W'(w_accept);

    issue_cnt_d = issue_cnt_q;
    if (w_start_go) begin
      issue_cnt_d = '0;
    end else if (w_accept) begin
      issue_cnt_d = issue_cnt_q + CNT_W'(1);
    end

    // acc and mul_res are both < P, so one conditional subtract suffices
    w_sum = {1'b0, acc_q} + {1'b0, bus.mul_res};
    acc_d = acc_q;
    if (w_start_go) begin
      acc_d = '0;
    end else if (w_tail_tok) begin
      if (w_sum >= {1'b0, MODULUS}) begin
        acc_d = DATA_WIDTH'(w_sum - {1'b0, MODULUS});
      end else begin
        acc_d = w_sum[DATA_WIDTH-1:0];
      end
    end
  end

  // Datapath registers; reset discards any products still in flight
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mul_x_q     <= '0;
      mul_y_q     <= '0;
      tok_q       <= '0;
      issue_cnt_q <= '0;
      acc_q       <= '0;
    end else begin
      mul_x_q     <= mul_x_d;
      mul_y_q     <= mul_y_d;
      tok_q       <= tok_d;
      issue_cnt_q <= issue_cnt_d;
      acc_q       <= acc_d;
    end
  end

  assign bus.busy      = w_busy;
  assign bus.in_ready  = w_in_ready;
  assign bus.out_valid = w_out_valid;
  assign bus.mul_x     = mul_x_q;
  assign bus.mul_y     = mul_y_q;
  assign bus.out_hash  = acc_q;

endmodule
`default_nettype wire
